ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_pkg.sv | 14 +
 rtl/fifo_out_buf.sv | 59 +++++
 rtl/ram_fifo_ctrl.sv | 112 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared defaults and types for the RAM-backed FIFO controller.
//   DefaultAddrW / DefaultDataW : default RAM address and data widths
//   addr_t, data_t, cnt_t       : address, data and occupancy-count types at the defaults
package ram_fifo_pkg;

  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned DefaultDataW = 8;

  typedef logic [DefaultAddrW-1:0] addr_t;
  typedef logic [DefaultDataW-1:0] data_t;
  // RAM holds up to 2^AddrW entries, plus 2 in the output buffer.
  typedef logic [DefaultAddrW+1:0] cnt_t;

endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry output buffer that holds words prefetched from the RAM.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous empty; wins over push and pop
//   push, push_data: write a word (never issued when already holding 2 without a pop)
//   pop            : drop the head word
//   head_data      : oldest word held
//   occupancy      : number of words held (0..2)
module fifo_out_buf
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] mem_q [2];
  logic              rd_idx_q, rd_idx_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_idx;

  // With two slots the write slot is the head slot, or the other one when a word is held.
  assign wr_idx = rd_idx_q ^ occ_q[0];

  always_comb begin
    rd_idx_d = rd_idx_q;
    occ_d    = occ_q;
    if (clear) begin
      rd_idx_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (pop) rd_idx_d = ~rd_idx_q;
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_idx_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      rd_idx_q <= rd_idx_d;
      occ_q    <= occ_d;
      if (push && !clear) mem_q[wr_idx] <= push_data;
    end
  end

  assign head_data = mem_q[rd_idx_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller around an external 1-write/1-read synchronous RAM
// (read data valid the cycle after the read enable), with a 2-entry prefetch buffer.
//   clock, reset_n                   : clock and asynchronous active-low reset
//   flush                            : synchronous clear of all queued data
//   in_valid, in_ready, in_data      : push handshake
//   out_valid, out_ready, out_data   : pop handshake; out_data is the oldest entry
//   count                            : entries held (RAM + in-flight + output buffer)
//   ram_write_en/address, ram_data_in: RAM write port
//   ram_read_en/address, ram_data_out: RAM read port
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] count,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_read_address,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_count_q, ram_count_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic              inflight_q, inflight_d;

  logic       push, pop, read_issue, buf_room;
  logic [1:0] buf_occ;

  // ram_count never exceeds 2^ADDR_W, so its top bit alone flags "full". reset_n keeps
  // the write port quiet while reset is held.
  assign in_ready = reset_n & ~flush & ~ram_count_q[ADDR_W];
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Only fetch when the word will have a slot on arrival: buffer + in-flight - pop < 2.
  assign buf_room   = ({1'b0, buf_occ} + {2'b00, inflight_q}) < ({2'b00, pop} + 3'd2);
  assign read_issue = (|ram_count_q) & ~flush & buf_room;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      count_d     = '0;
      inflight_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (read_issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      ram_count_d = ram_count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(read_issue);
      count_d     = count_q + (ADDR_W+2)'(push) - (ADDR_W+2)'(pop);
      inflight_d  = read_issue;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
    end
  end

  // A word returning during a flush cycle is dropped by the buffer's clear.
  fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (inflight_q),
    .push_data (ram_data_out),
    .pop       (pop),
    .head_data (out_data),
    .occupancy (buf_occ)
  );

  assign out_valid         = |buf_occ;
  assign count             = count_q;
  assign ram_write_en      = push;
  assign ram_write_address = wr_ptr_q;
  assign ram_data_in       = in_data;
  assign ram_read_en       = read_issue;
  assign ram_read_address  = rd_ptr_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic  clock = 1'b0;
  logic  reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  data_t in_data, out_data, ram_data_in, ram_data_out;
  cnt_t  count;
  logic  ram_write_en, ram_read_en;
  addr_t ram_write_address, ram_read_address;

  always #5 clock = ~clock;

  ram_fifo_ctrl dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .count             (count),
    .ram_write_en      (ram_write_en),
    .ram_write_address (ram_write_address),
    .ram_data_in       (ram_data_in),
    .ram_read_en       (ram_read_en),
    .ram_read_address  (ram_read_address),
    .ram_data_out      (ram_data_out)
  );

  // External synchronous RAM: read data appears the cycle after ram_read_en.
  data_t ram_mem [256];
  always @(posedge clock) begin
    if (ram_write_en) ram_mem[ram_write_address] <= ram_data_in;
    if (ram_read_en) ram_data_out <= ram_mem[ram_read_address];
  end

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pops = 0;
  data_t q[$];  // reference model: every entry the FIFO should be holding, oldest first

  // Values sampled at the most recent negedge by cycle().
  logic  s_ov, s_ir, s_ren;
  data_t s_od;
  cnt_t  s_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, update the model.
  task automatic cycle(input logic iv, input data_t id, input logic ordy, input logic fl);
    logic psh, pp;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clock);
    s_ov = out_valid; s_ir = in_ready; s_ren = ram_read_en; s_od = out_data; s_count = count;
    psh = in_valid & in_ready;
    pp  = out_valid & out_ready;
    chk("count", 32'(count), 32'(q.size()));
    chk("count_max", 32'(count <= 258), 32'd1);
    chk("write_en", 32'(ram_write_en), 32'(psh));
    if (q.size() == 0) chk("valid_when_empty", 32'(out_valid), 32'd0);
    if (fl) chk("ready_in_flush", 32'(in_ready), 32'd0);
    else if (q.size() < 256) chk("ready_not_full", 32'(in_ready), 32'd1);
    if (pp) begin
      if (q.size() == 0) chk("pop_from_empty", 32'd1, 32'd0);
      else chk("out_data", 32'(out_data), 32'(q[0]));
    end
    if (fl) q.delete();
    else begin
      if (pp && q.size() != 0) void'(q.pop_front());
      if (psh) q.push_back(in_data);
    end
    n_push += int'(psh);
    n_pops += int'(pp);
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && q.size() != 0; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_done", 32'(q.size()), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input string name, input data_t exp, input int budget);
    for (int k = 0; k < budget; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (s_ov) break;
    end
    chk({name, "_valid"}, 32'(s_ov), 32'd1);
    chk({name, "_data"}, 32'(s_od), 32'(exp));
  endtask

  typedef struct {
    logic  iv;
    data_t id;
    logic  ordy;
    cnt_t  e_count;
    logic  e_ov;
    logic  e_chk_data;
    data_t e_data;
    logic  e_wen;
    logic  e_ren;
    logic  e_rdy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p0;
    // Single push of 0xA5 into an empty controller: visible three cycles later.
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 10'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 10'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 10'd1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clock);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_write_en", 32'(ram_write_en), 32'd0);
    chk("rst_read_en", 32'(ram_read_en), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy; flush = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_write_en", i), 32'(ram_write_en), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d_read_en", i), 32'(ram_read_en), 32'(vecs[i].e_ren));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      if (vecs[i].e_chk_data) chk($sformatf("vec%0d_out_data", i), 32'(out_data),
                                  32'(vecs[i].e_data));
      @(posedge clock);
      #1;
    end

    // Fill: 256 RAM entries plus 2 buffered, further pushes refused.
    p0 = n_push;
    for (int i = 0; i < 262; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_accepted", 32'(n_push - p0), 32'd258);
    chk("fill_count", 32'(s_count), 32'd258);
    chk("fill_in_ready", 32'(s_ir), 32'd0);
    drain(400);

    // Streaming: one pop per cycle from the fourth cycle on, pointers wrap several times.
    p0 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 3) p0 = n_pops;
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
    end
    chk("stream_rate", 32'(n_pops - p0), 32'd997);
    drain(50);

    // Random handshakes on both sides.
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain(600);

    // Flush the cycle after a read issue with 5 queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_pre_read_en", 32'(s_ren), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_read_en", 32'(s_ren), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_count", 32'(s_count), 32'd0);
      chk("flush_out_valid", 32'(s_ov), 32'd0);
    end
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    wait_valid("flush_next", 8'h77, 10);
    drain(10);

    // Asynchronous reset mid-stream with 20 queued and a read in flight.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_write_en", 32'(ram_write_en), 32'd0);
    chk("mid_rst_read_en", 32'(ram_read_en), 32'd0);
    q.delete();
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_in_ready", 32'(s_ir), 32'd1);
    wait_valid("post_rst_first", 8'h3C, 10);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
